frame_buffer_scheduler: RTL and testbench

Sequences and arbitrates the single-port 36-bit frame-buffer BRAM shared by the NTSC capture writer and the VGA display reader. The BRAM is split into two banks (ping-pong) selected by the address MSB. The block admits one access per cycle, giving reads priority. It swaps banks only at VGA vsync, after the writer has finished a whole frame, so the display never shows a torn frame. It sits between the capture/display pipelines and the BRAM primitive.

---
 rtl/fb_pkg.sv | 13 +
 rtl/frame_buffer_scheduler_if.sv | 35 +++
 rtl/fb_grant_arb.sv | 43 ++++
 rtl/frame_buffer_scheduler.sv | 113 +++++++++++
 tb/tb_frame_buffer_scheduler.sv | 208 ++++++++++++++++++++
 5 files changed

// File: rtl/fb_pkg.sv
// Shared types and default widths for the frame-buffer scheduler slice.
package fb_pkg;

    localparam int FB_ADDR_W = 14;
    localparam int FB_DATA_W = 36;

    typedef enum logic [1:0] {
        WR_IDLE = 2'd0,
        WR_FILL = 2'd1,
        WR_HOLD = 2'd2
    } wr_state_e;

endpackage

// File: rtl/frame_buffer_scheduler_if.sv
// Capture/display handshakes plus the BRAM port, bundled for the scheduler.
interface frame_buffer_scheduler_if
    import fb_pkg::*;
#(
    parameter int ADDR_W = FB_ADDR_W,
    parameter int DATA_W = FB_DATA_W
) ();

    logic              wr_req;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;
    logic              wr_ack;

    logic              rd_req;
    logic [ADDR_W-1:0] rd_addr;
    logic              rd_ack;
    logic              rd_valid;
    logic [DATA_W-1:0] rd_data;

    logic [ADDR_W:0]   bram_addr;
    logic [DATA_W-1:0] bram_din;
    logic              bram_we;
    logic [DATA_W-1:0] bram_dout;

    modport slave (
        input  wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_dout,
        output wr_ack, rd_ack, rd_valid, rd_data, bram_addr, bram_din, bram_we
    );

    modport master (
        output wr_req, wr_addr, wr_data, rd_req, rd_addr, bram_dout,
        input  wr_ack, rd_ack, rd_valid, rd_data, bram_addr, bram_din, bram_we
    );

endinterface

// File: rtl/fb_grant_arb.sv
// Read-priority grant for the shared BRAM port; FB_STARVE_GUARD_EN adds a
// starvation counter that forces a write after STARVE_MAX blocked cycles.
module fb_grant_arb #(
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic fill,
    input  logic rd_req,
    input  logic wr_req,
    output logic rd_gnt,
    output logic wr_gnt
);

`ifdef FB_STARVE_GUARD_EN
    localparam int CNT_W = $clog2(STARVE_MAX + 1);

    logic [CNT_W-1:0] starve_cnt;
    logic             force_wr;

    assign force_wr = fill && wr_req && (starve_cnt == CNT_W'(STARVE_MAX));
    assign rd_gnt   = rd_req && !force_wr;
    assign wr_gnt   = fill && wr_req && (!rd_req || force_wr);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            starve_cnt <= '0;
        end else if (!fill || wr_gnt) begin
            starve_cnt <= '0;
        end else if (wr_req && rd_gnt) begin
            starve_cnt <= starve_cnt + CNT_W'(1);
        end
    end
`else
    // Strict read priority: reads are served in every writer state.
    assign rd_gnt = rd_req;
    assign wr_gnt = fill && wr_req && !rd_req;

    logic unused_arb;
    assign unused_arb = ^{clk, reset_n, 32'(STARVE_MAX)};
`endif

endmodule

// File: rtl/frame_buffer_scheduler.sv
// Ping-pong frame-buffer port scheduler: writer FSM, bank swap at vsync and
// registered read return. Optional FB_STARVE_GUARD_EN enables write anti-starvation.
//
// state   | meaning
// WR_IDLE | no capture frame open; writes acked and discarded
// WR_FILL | capturing into wr_bank; writes arbitrated onto the port
// WR_HOLD | full frame captured, waiting for vsync to swap banks
module frame_buffer_scheduler
    import fb_pkg::*;
#(
    parameter int ADDR_W     = FB_ADDR_W,
    parameter int DATA_W     = FB_DATA_W,
    parameter int STARVE_MAX = 4
) (
    input  logic clk,
    input  logic reset_n,
    input  logic frame_flag,
    input  logic vsync,
    output logic rd_bank,
    output logic wr_bank,
    output logic frame_dropped,
    frame_buffer_scheduler_if.slave bus
);

    wr_state_e         state_q, state_d;
    logic              swap, drop;
    logic              fill;
    logic              rd_gnt, wr_gnt;
    logic              rd_bank_q;
    logic              drop_q;
    logic [ADDR_W:0]   addr_q, addr_nxt;
    logic              rd_pend_q;
    logic              rd_valid_q;
    logic [DATA_W-1:0] rd_data_q;

    assign fill = (state_q == WR_FILL);

    fb_grant_arb #(
        .STARVE_MAX (STARVE_MAX)
    ) u_arb (
        .clk     (clk),
        .reset_n (reset_n),
        .fill    (fill),
        .rd_req  (bus.rd_req),
        .wr_req  (bus.wr_req),
        .rd_gnt  (rd_gnt),
        .wr_gnt  (wr_gnt)
    );

    always_comb begin
        state_d = state_q;
        swap    = 1'b0;
        drop    = 1'b0;
        case (state_q)
            WR_IDLE: if (frame_flag) state_d = WR_FILL;
            WR_FILL: if (frame_flag) state_d = WR_HOLD;
            WR_HOLD: begin
                if (vsync) begin
                    swap    = 1'b1;
                    state_d = frame_flag ? WR_FILL : WR_IDLE;
                end else if (frame_flag) begin
                    drop = 1'b1;
                end
            end
            default: state_d = WR_IDLE;
        endcase
    end

    // An idle port keeps presenting the last granted address.
    always_comb begin
        addr_nxt = addr_q;
        if (rd_gnt) begin
            addr_nxt = {rd_bank_q, bus.rd_addr};
        end else if (wr_gnt) begin
            addr_nxt = {~rd_bank_q, bus.wr_addr};
        end
    end

    assign bus.bram_addr = reset_n ? addr_nxt : '0;
    assign bus.bram_we   = reset_n && wr_gnt;
    assign bus.bram_din  = (reset_n && wr_gnt) ? bus.wr_data : '0;
    assign bus.rd_ack    = reset_n && rd_gnt;
    assign bus.wr_ack    = reset_n && (wr_gnt || (bus.wr_req && !fill));

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= WR_IDLE;
            rd_bank_q  <= 1'b0;
            drop_q     <= 1'b0;
            addr_q     <= '0;
            rd_pend_q  <= 1'b0;
            rd_valid_q <= 1'b0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            rd_bank_q  <= rd_bank_q ^ swap;
            drop_q     <= drop;
            addr_q     <= addr_nxt;
            rd_pend_q  <= rd_gnt;
            rd_valid_q <= rd_pend_q;
            if (rd_pend_q) begin
                rd_data_q <= bus.bram_dout;
            end
        end
    end

    assign rd_bank       = rd_bank_q;
    assign wr_bank       = ~rd_bank_q;
    assign frame_dropped = drop_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.rd_data   = rd_data_q;

endmodule

// File: tb/tb_frame_buffer_scheduler.sv
// Directed-vector bench for frame_buffer_scheduler with a behavioural BRAM.
module tb_frame_buffer_scheduler;

    logic clk = 1'b0;
    logic reset_n = 1'b0;
    logic frame_flag = 1'b0;
    logic vsync = 1'b0;
    logic rd_bank, wr_bank, frame_dropped;

    int n_checks = 0;
    int n_fail   = 0;

    frame_buffer_scheduler_if #(.ADDR_W(14), .DATA_W(36)) bus ();

    frame_buffer_scheduler #(.ADDR_W(14), .DATA_W(36), .STARVE_MAX(4)) dut (
        .clk           (clk),
        .reset_n       (reset_n),
        .frame_flag    (frame_flag),
        .vsync         (vsync),
        .rd_bank       (rd_bank),
        .wr_bank       (wr_bank),
        .frame_dropped (frame_dropped),
        .bus           (bus)
    );

    always #5 clk = ~clk;

    logic [35:0] mem [0:32767];
    logic [35:0] dout_r;
    always @(posedge clk) begin
        if (bus.bram_we) mem[bus.bram_addr] <= bus.bram_din;
        dout_r <= mem[bus.bram_addr];
    end
    assign bus.bram_dout = dout_r;

    typedef struct {
        logic        ff, vs, wreq;
        logic [13:0] waddr;
        logic [35:0] wdata;
        logic        rreq;
        logic [13:0] raddr;
        logic        e_wack, e_rack, e_we;
        logic [14:0] e_addr;
        logic [35:0] e_din;
        logic        e_rbank, e_drop, e_rvalid;
        logic [35:0] e_rdata;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(input logic ff, vs, wreq, input int waddr, input logic [35:0] wdata,
                                input logic rreq, input int raddr, input logic wack, rack, we,
                                input int addr, input logic [35:0] din, input logic rbank, drop, rvalid,
                                input logic [35:0] rdata);
        vec_t v;
        v.ff = ff; v.vs = vs; v.wreq = wreq; v.waddr = 14'(waddr); v.wdata = wdata;
        v.rreq = rreq; v.raddr = 14'(raddr);
        v.e_wack = wack; v.e_rack = rack; v.e_we = we; v.e_addr = 15'(addr); v.e_din = din;
        v.e_rbank = rbank; v.e_drop = drop; v.e_rvalid = rvalid; v.e_rdata = rdata;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic ff, vs, wreq, input logic [13:0] waddr, input logic [35:0] wdata,
                         input logic rreq, input logic [13:0] raddr);
        frame_flag  = ff;
        vsync       = vs;
        bus.wr_req  = wreq;
        bus.wr_addr = waddr;
        bus.wr_data = wdata;
        bus.rd_req  = rreq;
        bus.rd_addr = raddr;
    endtask

    task automatic idle_cycle();
        @(posedge clk); #1;
        drive(0, 0, 0, 14'd0, 36'd0, 0, 14'd0);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 32768; i++) mem[i] = '0;

        // Reset state, with both requesters active to prove outputs stay quiet.
        drive(0, 0, 1, 14'd5, 36'h111, 1, 14'd5);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("reset wr_ack", 64'(bus.wr_ack), 64'd0);
        chk("reset rd_ack", 64'(bus.rd_ack), 64'd0);
        chk("reset bram_we", 64'(bus.bram_we), 64'd0);
        chk("reset bram_addr", 64'(bus.bram_addr), 64'd0);
        chk("reset rd_valid", 64'(bus.rd_valid), 64'd0);
        chk("reset rd_data", 64'(bus.rd_data), 64'd0);
        chk("reset rd_bank", 64'(rd_bank), 64'd0);
        chk("reset wr_bank", 64'(wr_bank), 64'd1);
        chk("reset frame_dropped", 64'(frame_dropped), 64'd0);
        @(posedge clk); #1;
        drive(0, 0, 0, 14'd0, 36'd0, 0, 14'd0);
        reset_n = 1'b1;

        //                ff vs wr wa     wdata     rr ra   wak rak we addr     din       rb dr rv rdata
        tbl.push_back(mk(0, 0, 1, 5,  36'h111, 0, 0,  1, 0, 0, 'h0000, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(1, 0, 1, 3,  36'hABC, 0, 0,  1, 0, 0, 'h0000, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 1, 3,  36'hABC, 0, 0,  1, 0, 1, 'h4003, 36'hABC, 0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 1, 4,  36'h55,  1, 7,  0, 1, 0, 'h0007, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 1, 4,  36'h55,  0, 0,  1, 0, 1, 'h4004, 36'h55,  0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4004, 36'h0,   0, 0, 1, 36'h0));
        tbl.push_back(mk(0, 1, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4004, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(1, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4004, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 1, 9,  36'h999, 1, 2,  1, 1, 0, 'h0002, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(1, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h0002, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(1, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h0002, 36'h0,   0, 1, 1, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h0002, 36'h0,   0, 1, 0, 36'h0));
        tbl.push_back(mk(0, 1, 0, 0,  36'h0,   1, 3,  0, 1, 0, 'h0003, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   1, 3,  0, 1, 0, 'h4003, 36'h0,   1, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4003, 36'h0,   1, 0, 1, 36'h0));
        tbl.push_back(mk(1, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4003, 36'h0,   1, 0, 1, 36'hABC));
        tbl.push_back(mk(0, 0, 1, 3,  36'h123, 0, 0,  1, 0, 1, 'h0003, 36'h123, 1, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   1, 3,  0, 1, 0, 'h4003, 36'h0,   1, 0, 0, 36'h0));
        tbl.push_back(mk(1, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4003, 36'h0,   1, 0, 0, 36'h0));
        tbl.push_back(mk(1, 1, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h4003, 36'h0,   1, 0, 1, 36'hABC));
        tbl.push_back(mk(0, 0, 1, 8,  36'h777, 0, 0,  1, 0, 1, 'h4008, 36'h777, 0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   1, 3,  0, 1, 0, 'h0003, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h0003, 36'h0,   0, 0, 0, 36'h0));
        tbl.push_back(mk(0, 0, 0, 0,  36'h0,   0, 0,  0, 0, 0, 'h0003, 36'h0,   0, 0, 1, 36'h123));

        foreach (tbl[i]) begin
            @(posedge clk); #1;
            drive(tbl[i].ff, tbl[i].vs, tbl[i].wreq, tbl[i].waddr, tbl[i].wdata, tbl[i].rreq, tbl[i].raddr);
            @(negedge clk);
            chk($sformatf("row%0d wr_ack", i), 64'(bus.wr_ack), 64'(tbl[i].e_wack));
            chk($sformatf("row%0d rd_ack", i), 64'(bus.rd_ack), 64'(tbl[i].e_rack));
            chk($sformatf("row%0d bram_we", i), 64'(bus.bram_we), 64'(tbl[i].e_we));
            chk($sformatf("row%0d bram_addr", i), 64'(bus.bram_addr), 64'(tbl[i].e_addr));
            chk($sformatf("row%0d bram_din", i), 64'(bus.bram_din), 64'(tbl[i].e_din));
            chk($sformatf("row%0d rd_bank", i), 64'(rd_bank), 64'(tbl[i].e_rbank));
            chk($sformatf("row%0d wr_bank", i), 64'(wr_bank), 64'(!tbl[i].e_rbank));
            chk($sformatf("row%0d frame_dropped", i), 64'(frame_dropped), 64'(tbl[i].e_drop));
            chk($sformatf("row%0d rd_valid", i), 64'(bus.rd_valid), 64'(tbl[i].e_rvalid));
            if (tbl[i].e_rvalid)
                chk($sformatf("row%0d rd_data", i), 64'(bus.rd_data), 64'(tbl[i].e_rdata));
        end

        // Still in FILL: continuous contention between reader and writer.
        for (int i = 0; i < 15; i++) begin
            logic exp_w;
`ifdef FB_STARVE_GUARD_EN
            exp_w = ((i % 5) == 4);
`else
            exp_w = 1'b0;
`endif
            @(posedge clk); #1;
            drive(0, 0, 1, 14'd10, 36'h9, 1, 14'd1);
            @(negedge clk);
            chk($sformatf("starve%0d wr_ack", i), 64'(bus.wr_ack), 64'(exp_w));
            chk($sformatf("starve%0d rd_ack", i), 64'(bus.rd_ack), 64'(!exp_w));
        end

        // Close the frame and swap so the reset check has a non-default bank to undo.
        @(posedge clk); #1;
        drive(1, 0, 0, 14'd0, 36'd0, 0, 14'd0);
        @(posedge clk); #1;
        drive(0, 1, 0, 14'd0, 36'd0, 0, 14'd0);
        idle_cycle();
        chk("pre-reset rd_bank", 64'(rd_bank), 64'd1);

        @(posedge clk); #1;
        drive(0, 0, 0, 14'd0, 36'd0, 1, 14'd3);
        @(negedge clk);
        chk("pre-reset read rd_ack", 64'(bus.rd_ack), 64'd1);
        @(posedge clk); #1;
        reset_n = 1'b0;
        drive(0, 0, 1, 14'd2, 36'h5, 1, 14'd3);
        @(negedge clk);
        chk("mid-reset rd_ack", 64'(bus.rd_ack), 64'd0);
        chk("mid-reset wr_ack", 64'(bus.wr_ack), 64'd0);
        chk("mid-reset bram_addr", 64'(bus.bram_addr), 64'd0);
        chk("mid-reset rd_bank", 64'(rd_bank), 64'd0);
        chk("mid-reset wr_bank", 64'(wr_bank), 64'd1);
        @(posedge clk); #1;
        drive(0, 0, 0, 14'd0, 36'd0, 0, 14'd0);
        reset_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk($sformatf("post-reset%0d rd_valid", i), 64'(bus.rd_valid), 64'd0);
            @(posedge clk); #1;
        end
        chk("post-reset rd_bank", 64'(rd_bank), 64'd0);
        chk("post-reset wr_bank", 64'(wr_bank), 64'd1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
